// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: sequential word fetch, in-order
// instruction queue toward decode, redirect flush with stale-response drop.
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CW + 1;
    localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_seq_pc;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop;
    logic [31:0]   r_q_pc    [DEPTH];
    logic [31:0]   r_q_instr [DEPTH];

    logic [31:0]   w_redir_pc;
    logic [SW-1:0] w_used;
    logic          w_credit;
    logic          w_req_fire;
    logic          w_drop_rsp;
    logic          w_enq;
    logic          w_deq;
    logic          w_unused;

    // low address bits of a redirect target are ignored
    assign w_unused   = ^redirect_pc[1:0];
    assign w_redir_pc = {redirect_pc[31:2], 2'b00};

    // queued + live + stale requests must never exceed the queue size
    assign w_used   = SW'(r_count) + SW'(r_inflight) + SW'(r_drop);
    assign w_credit = (w_used < DEPTH_S);

    assign imem_req_valid = !rst && !redirect_valid && w_credit;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_drop_rsp = imem_rsp_valid && (r_drop != '0);
    assign w_enq      = imem_rsp_valid && (r_drop == '0) && !redirect_valid;

    assign out_valid = !rst && (r_count != '0);
    assign out_instr = r_q_instr[r_head];
    assign out_pc    = r_q_pc[r_head];
    assign w_deq     = out_valid && out_ready;

    // fetch pointer, queue pointers and request accounting
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_seq_pc   <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redir_pc;
            r_seq_pc   <= w_redir_pc;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop     <= r_drop + r_inflight - CW'(imem_rsp_valid);
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_enq) begin
                r_seq_pc <= r_seq_pc + 32'd4;
                r_tail   <= r_tail + AW'(1);
            end
            if (w_deq) begin
                r_head <= r_head + AW'(1);
            end
            r_count    <= r_count + CW'(w_enq) - CW'(w_deq);
            r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_enq);
            if (w_drop_rsp) begin
                r_drop <= r_drop - CW'(1);
            end
        end
    end

    // queue storage written at the tail on each live response
    always_ff @(posedge clk) begin
        if (!rst && w_enq) begin
            r_q_pc[r_tail]    <= r_seq_pc;
            r_q_instr[r_tail] <= imem_rsp_data;
        end
    end

    // credit accounting must rule out overflow and unsolicited responses
    always_ff @(posedge clk) begin
        if (!rst && w_enq) begin
            assert (r_count != DEPTH_C);
        end
        if (!rst && imem_rsp_valid) begin
            assert ((r_inflight != '0) || (r_drop != '0));
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: memory model with latency,
// expected-entry scoreboard, redirect and wrap scenarios.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    always #5 clk = ~clk;

    instr_fetch_queue #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    pend_t       pend[$];
    ent_t        exp_q[$];
    int          n_cmp;
    int          n_err;
    int          cyc;
    int          lat;
    int          n_out;
    int          n_req;
    logic [31:0] exp_fetch;
    logic [31:0] fire_addr_now;
    logic [31:0] prev_fire;
    bit          fired_now;
    bit          out_now;
    bit          got;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp_v);
        end
    endtask

    // observe one cycle at the falling edge and update the models
    task automatic sample();
        pend_t p;
        ent_t  e;
        @(negedge clk);
        fired_now     = imem_req_valid && imem_req_ready;
        out_now       = out_valid && out_ready && !redirect_valid;
        fire_addr_now = imem_req_addr;
        if (imem_rsp_valid && pend.size() > 0) begin
            void'(pend.pop_front());
        end
        if (redirect_valid) begin
            exp_q.delete();
            exp_fetch = {redirect_pc[31:2], 2'b00};
        end
        if (out_now) begin
            n_out++;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_out", out_pc, 32'hDEAD_BEEF);
            end else begin
                e = exp_q.pop_front();
                chk("out_pc", out_pc, e.pc);
                chk("out_instr", out_instr, e.instr);
            end
        end
        if (fired_now) begin
            n_req++;
            p.addr = imem_req_addr;
            p.due  = cyc + lat;
            pend.push_back(p);
            if (!redirect_valid) begin
                chk("req_addr", imem_req_addr, exp_fetch);
                e.pc    = exp_fetch;
                e.instr = mem_word(exp_fetch);
                exp_q.push_back(e);
                exp_fetch = exp_fetch + 32'd4;
            end
        end
    endtask

    // step past the rising edge and present the next memory response
    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic wait_first_out(input string tag, input logic [31:0] pc);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            sample();
            if (out_now) begin
                got = 1'b1;
                chk(tag, out_pc, pc);
            end
            advance();
        end
        if (!got) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end
    endtask

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        cyc            = 0;
        lat            = 1;
        n_out          = 0;
        n_req          = 0;
        exp_fetch      = 32'h0;
        prev_fire      = 32'h0;
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;

        // reset state
        repeat (2) tick();
        sample();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        advance();

        // release, decode stalled: fill to exactly DEPTH entries
        rst            = 1'b0;
        imem_req_ready = 1'b1;
        n_req          = 0;
        sample();
        chk("c0_req_valid", imem_req_valid, 1);
        chk("c0_req_addr", imem_req_addr, 32'h0);
        chk("c0_out_valid", out_valid, 0);
        advance();
        sample();
        chk("c1_no_bypass", out_valid, 0);
        advance();
        sample();
        chk("c2_out_valid", out_valid, 1);
        chk("c2_out_pc", out_pc, 32'h0);
        advance();
        repeat (6) tick();
        sample();
        chk("full_req_count", n_req, 4);
        chk("full_req_valid", imem_req_valid, 0);
        chk("full_head_pc", out_pc, 32'h0);
        advance();

        // decode resumes: fetch continues at 0x10
        out_ready = 1'b1;
        got       = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            sample();
            if (fired_now) begin
                got = 1'b1;
                chk("resume_addr", fire_addr_now, 32'h10);
            end
            advance();
        end
        if (!got) chk("resume_timeout", 32'd0, 32'd1);

        // steady state: one instruction per cycle
        repeat (6) tick();
        n_out = 0;
        repeat (16) tick();
        chk("throughput", n_out, 16);

        // memory stalls: address held
        imem_req_ready = 1'b0;
        repeat (5) begin
            sample();
            chk("stall_valid", imem_req_valid, 1);
            chk("stall_addr", imem_req_addr, exp_fetch);
            advance();
        end
        repeat (4) tick();
        chk("stall_drained", out_valid, 0);

        // three live requests at long latency, then redirect
        lat            = 4;
        imem_req_ready = 1'b1;
        repeat (3) tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        sample();
        chk("redir_req_valid", imem_req_valid, 0);
        advance();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        sample();
        chk("redir_next_addr", imem_req_addr, 32'h100);
        advance();
        wait_first_out("redir_first_pc", 32'h100);

        // redirect coinciding with a response and an out handshake
        lat = 1;
        repeat (10) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        sample();
        chk("rr_out_valid_pre", out_valid, 1);
        advance();
        redirect_valid = 1'b0;
        sample();
        chk("rr_out_valid_post", out_valid, 0);
        chk("rr_req_addr", imem_req_addr, 32'h100);
        advance();
        wait_first_out("rr_first_pc", 32'h100);

        // fetch address wraps past the top of memory
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        got            = 1'b0;
        prev_fire      = 32'h0;
        for (int i = 0; i < 12 && !got; i++) begin
            sample();
            if (fired_now) begin
                if (prev_fire == 32'hFFFF_FFFC) begin
                    got = 1'b1;
                    chk("wrap_addr", fire_addr_now, 32'h0);
                end
                prev_fire = fire_addr_now;
            end
            advance();
        end
        if (!got) chk("wrap_timeout", 32'd0, 32'd1);
        repeat (10) tick();

        // drain: every expected entry must have been delivered
        imem_req_ready = 1'b0;
        repeat (10) tick();
        chk("drain_empty", exp_q.size(), 0);
        sample();
        chk("drain_out_valid", out_valid, 0);
        advance();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
